// File: rtl/c4_game_ctrl.sv
// Connect-Four game-state controller: selector movement, gravity drop, sequential
// 4-in-a-row check around the last disc, winning-run marking and draw detection.
module c4_game_ctrl #(
    parameter int START_COL = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_drop,
    input  logic                  btn_new,
    output logic [5:0][6:0][1:0]  panel,
    output logic [6:0]            play,
    output logic                  player,
    output logic                  win_a,
    output logic                  win_b,
    output logic                  game_over,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIND,
        S_CHECK,
        S_MARK,
        S_WIN,
        S_DRAW
    } state_t;

    localparam logic [2:0] START_SEL  = 3'(START_COL);
    localparam logic [6:0] START_PLAY = 7'(1 << START_COL);

    state_t      state;
    logic [2:0]  sel;
    logic [2:0]  row;
    logic [5:0]  discs;
    logic [1:0]  dir;
    logic        side;
    logic [1:0]  step;
    logic [1:0]  fwd;
    logic [1:0]  bwd;
    logic [2:0]  mark_r;
    logic [2:0]  mark_c;
    logic [2:0]  mark_left;

    logic [1:0]  owner;
    logic        dr_down;
    logic        dc_pos;
    logic        dc_neg;
    logic [4:0]  off_r;
    logic [4:0]  off_c;
    logic [4:0]  probe_r;
    logic [4:0]  probe_c;
    logic        col_sub;
    logic        probe_inb;
    logic [2:0]  pr_i;
    logic [2:0]  pc_i;
    logic        probe_hit;
    logic [1:0]  cnt_next;
    logic        side_done;
    logic [2:0]  run_m1;
    logic [2:0]  start_r;
    logic [2:0]  start_c;

    // Directions in order H, V, D, A; rows grow downward, so every non-H direction has drow = +1.
    // Probe coordinates use 5-bit unsigned arithmetic: a negative result wraps high and fails the bound test.
    always_comb begin
        owner     = player ? 2'b10 : 2'b01;
        dr_down   = (dir != 2'd0);
        dc_pos    = (dir == 2'd0) || (dir == 2'd2);
        dc_neg    = (dir == 2'd3);
        off_r     = dr_down ? {3'b000, step} : 5'd0;
        off_c     = (dc_pos || dc_neg) ? {3'b000, step} : 5'd0;
        probe_r   = side ? ({2'b00, row} - off_r) : ({2'b00, row} + off_r);
        col_sub   = side ^ dc_neg;
        probe_c   = col_sub ? ({2'b00, sel} - off_c) : ({2'b00, sel} + off_c);
        probe_inb = (probe_r < 5'd6) && (probe_c < 5'd7);
        pr_i      = probe_inb ? probe_r[2:0] : 3'd0;
        pc_i      = probe_inb ? probe_c[2:0] : 3'd0;
        probe_hit = probe_inb && (panel[pr_i][pc_i] == owner);
        cnt_next  = (side ? bwd : fwd) + {1'b0, probe_hit};
        side_done = !probe_hit || (step == 2'd3);
        run_m1    = {1'b0, fwd} + {1'b0, cnt_next};
        start_r   = dr_down ? (row - {1'b0, cnt_next}) : row;
        if (dc_pos)
            start_c = sel - {1'b0, cnt_next};
        else if (dc_neg)
            start_c = sel + {1'b0, cnt_next};
        else
            start_c = sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            panel     <= '0;
            play      <= START_PLAY;
            sel       <= START_SEL;
            player    <= 1'b0;
            win_a     <= 1'b0;
            win_b     <= 1'b0;
            game_over <= 1'b0;
            busy      <= 1'b0;
            discs     <= 6'd0;
            row       <= 3'd0;
            dir       <= 2'd0;
            side      <= 1'b0;
            step      <= 2'd1;
            fwd       <= 2'd0;
            bwd       <= 2'd0;
            mark_r    <= 3'd0;
            mark_c    <= 3'd0;
            mark_left <= 3'd0;
        end else if (btn_new) begin
            state     <= S_IDLE;
            panel     <= '0;
            play      <= START_PLAY;
            sel       <= START_SEL;
            player    <= 1'b0;
            win_a     <= 1'b0;
            win_b     <= 1'b0;
            game_over <= 1'b0;
            busy      <= 1'b0;
            discs     <= 6'd0;
            row       <= 3'd0;
            dir       <= 2'd0;
            side      <= 1'b0;
            step      <= 2'd1;
            fwd       <= 2'd0;
            bwd       <= 2'd0;
            mark_r    <= 3'd0;
            mark_c    <= 3'd0;
            mark_left <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn_drop) begin
                        if (panel[0][sel] == 2'b00) begin
                            state <= S_FIND;
                            busy  <= 1'b1;
                            row   <= 3'd5;
                        end
                    end else if (btn_left && !btn_right) begin
                        if (sel != 3'd0) begin
                            sel  <= sel - 3'd1;
                            play <= play >> 1;
                        end
                    end else if (btn_right && !btn_left) begin
                        if (sel != 3'd6) begin
                            sel  <= sel + 3'd1;
                            play <= play << 1;
                        end
                    end
                end

                S_FIND: begin
                    if (panel[row][sel] == 2'b00) begin
                        panel[row][sel] <= owner;
                        discs <= discs + 6'd1;
                        state <= S_CHECK;
                        dir   <= 2'd0;
                        side  <= 1'b0;
                        step  <= 2'd1;
                        fwd   <= 2'd0;
                        bwd   <= 2'd0;
                    end else begin
                        row <= row - 3'd1;
                    end
                end

                S_CHECK: begin
                    if (!side_done) begin
                        step <= step + 2'd1;
                        if (side)
                            bwd <= cnt_next;
                        else
                            fwd <= cnt_next;
                    end else if (!side) begin
                        fwd  <= cnt_next;
                        side <= 1'b1;
                        step <= 2'd1;
                    end else begin
                        bwd <= cnt_next;
                        // run = 1 + fwd + bwd, so a win is fwd + bwd >= 3
                        if (run_m1 >= 3'd3) begin
                            state     <= S_MARK;
                            mark_r    <= start_r;
                            mark_c    <= start_c;
                            mark_left <= run_m1;
                        end else if (dir != 2'd3) begin
                            dir  <= dir + 2'd1;
                            side <= 1'b0;
                            step <= 2'd1;
                            fwd  <= 2'd0;
                            bwd  <= 2'd0;
                        end else if (discs == 6'd42) begin
                            state     <= S_DRAW;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            player <= !player;
                            state  <= S_IDLE;
                            busy   <= 1'b0;
                        end
                    end
                end

                S_MARK: begin
                    panel[mark_r][mark_c] <= 2'b11;
                    if (mark_left == 3'd0) begin
                        state     <= S_WIN;
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        win_a     <= !player;
                        win_b     <= player;
                        play      <= 7'h7F;
                    end else begin
                        mark_left <= mark_left - 3'd1;
                        mark_r    <= mark_r + {2'b00, dr_down};
                        if (dc_pos)
                            mark_c <= mark_c + 3'd1;
                        else if (dc_neg)
                            mark_c <= mark_c - 3'd1;
                    end
                end

                S_WIN, S_DRAW: begin
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c4_game_ctrl.sv
// Directed bench for c4_game_ctrl: selector, gravity, win marking, full column,
// busy lockout, restart/reset aborts and a full 42-disc draw.
module tb_c4_game_ctrl;

    localparam int LEFT  = 0;
    localparam int RIGHT = 1;
    localparam int DROP  = 2;
    localparam int NEWG  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 btn_left, btn_right, btn_drop, btn_new;
    logic [5:0][6:0][1:0] panel;
    logic [6:0]           play;
    logic                 player, win_a, win_b, game_over, busy;

    int total = 0;
    int bad   = 0;
    int sel_m = 3;
    int ncyc;
    logic [5:0][6:0][1:0] exp_panel;
    logic [5:0][6:0][1:0] snap;

    int draw_cols[42] = '{0, 2, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1,
                          4, 3, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4,
                          5, 6, 6, 6, 6, 6, 6, 5, 5, 5, 5, 5};

    c4_game_ctrl #(.START_COL(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_drop  (btn_drop),
        .btn_new   (btn_new),
        .panel     (panel),
        .play      (play),
        .player    (player),
        .win_a     (win_a),
        .win_b     (win_b),
        .game_over (game_over),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            LEFT:    btn_left  = 1'b1;
            RIGHT:   btn_right = 1'b1;
            DROP:    btn_drop  = 1'b1;
            default: btn_new   = 1'b1;
        endcase
        @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        btn_new   = 1'b0;
        if (which == NEWG) sel_m = 3;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 200) check("busy_timeout", busy, 1'b0);
    endtask

    task automatic goto_col(input int col);
        while (sel_m > col) begin pulse(LEFT);  sel_m--; end
        while (sel_m < col) begin pulse(RIGHT); sel_m++; end
    endtask

    task automatic drop_at(input int col);
        int n;
        goto_col(col);
        pulse(DROP);
        wait_idle(n);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0; btn_new = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sel_m = 3;
        @(negedge clk);
    endtask

    task automatic win_prefix();
        drop_at(0); drop_at(0);
        drop_at(1); drop_at(1);
        drop_at(2); drop_at(2);
    endtask

    initial begin
        do_reset();
        check("rst_panel", panel, '0);
        check("rst_play", play, 7'b0001000);
        check("rst_player", player, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_over", {win_a, win_b, game_over}, 3'b000);

        // selector saturation
        repeat (4) pulse(LEFT);
        check("sat_left", play, 7'b0000001);
        repeat (10) pulse(RIGHT);
        check("sat_right", play, 7'b1000000);
        sel_m = 6;
        @(negedge clk);
        btn_left = 1'b1; btn_right = 1'b1;
        @(negedge clk);
        btn_left = 1'b0; btn_right = 1'b0;
        check("left_right_both", play, 7'b1000000);

        // first drop on empty board
        goto_col(3);
        check("back_to_3", play, 7'b0001000);
        pulse(DROP);
        wait_idle(ncyc);
        check("busy_cycles_empty", ncyc, 9);
        check("first_disc", panel[5][3], 2'b01);
        check("player_after_1", player, 1'b1);
        drop_at(3);
        check("second_disc", panel[4][3], 2'b10);
        check("player_after_2", player, 1'b0);

        // horizontal win for A on the bottom row
        pulse(NEWG);
        check("new_clears", panel, '0);
        win_prefix();
        goto_col(3);
        pulse(DROP);
        wait_idle(ncyc);
        check("busy_cycles_win", ncyc, 9);
        exp_panel = '0;
        for (int c = 0; c < 4; c++) exp_panel[5][c] = 2'b11;
        for (int c = 0; c < 3; c++) exp_panel[4][c] = 2'b10;
        check("win_panel", panel, exp_panel);
        check("win_flags", {win_a, win_b, game_over}, 3'b101);
        check("win_play", play, 7'h7F);
        check("win_player", player, 1'b0);
        pulse(DROP);
        pulse(LEFT);
        check("win_frozen_panel", panel, exp_panel);
        check("win_frozen_play", play, 7'h7F);
        check("win_frozen_busy", busy, 1'b0);

        // full column
        pulse(NEWG);
        for (int k = 0; k < 6; k++) drop_at(0);
        check("col0_top", panel[0][0], 2'b10);
        snap = panel;
        pulse(DROP);
        check("full_busy", busy, 1'b0);
        @(negedge clk);
        check("full_busy_later", busy, 1'b0);
        check("full_panel", panel, snap);
        check("full_player", player, 1'b0);

        // drop pulse while busy is dropped
        goto_col(1);
        pulse(DROP);
        check("busy_started", busy, 1'b1);
        pulse(DROP);
        wait_idle(ncyc);
        check("busy_drop_placed", panel[5][1], 2'b01);
        check("busy_drop_ignored", panel[4][1], 2'b00);
        check("busy_drop_player", player, 1'b1);

        // restart during CHECK
        pulse(DROP);
        repeat (2) @(negedge clk);
        check("mid_check_busy", busy, 1'b1);
        check("mid_check_disc", panel[4][1], 2'b10);
        pulse(NEWG);
        check("new_mid_panel", panel, '0);
        check("new_mid_busy", busy, 1'b0);
        check("new_mid_play", play, 7'b0001000);
        check("new_mid_player", player, 1'b0);

        // async reset during MARK
        win_prefix();
        goto_col(3);
        pulse(DROP);
        repeat (7) @(negedge clk);
        check("mid_mark_cell", panel[5][0], 2'b11);
        check("mid_mark_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_mark_panel", panel, '0);
        check("rst_mark_play", play, 7'b0001000);
        check("rst_mark_flags", {player, win_a, win_b, game_over, busy}, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        sel_m = 3;
        @(negedge clk);

        // 42-disc draw
        for (int k = 0; k < 41; k++) drop_at(draw_cols[k]);
        check("pre_draw_over", game_over, 1'b0);
        drop_at(draw_cols[41]);
        for (int rr = 0; rr < 6; rr++)
            for (int c = 0; c < 7; c++)
                exp_panel[rr][c] = ((((c >> 1) & 1) ^ ((5 - rr) & 1)) != 0) ? 2'b10 : 2'b01;
        check("draw_panel", panel, exp_panel);
        check("draw_flags", {win_a, win_b, game_over, busy}, 4'b0010);
        check("draw_play", play, 7'b0100000);
        pulse(LEFT);
        check("draw_frozen_play", play, 7'b0100000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
